axi_cfg_register: RTL and testbench

AXI_CFG_REGISTER -- requirements
Module: axi_cfg_register

---
 rtl/axi_cfg_register.sv | 119 +++++++++++
 tb/tb_axi_cfg_register.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_register.sv
// AXI4-Lite write-only configuration register bank. One AW buffer and one W
// buffer fill independently; a write commits once both are full and no response is pending.
module axi_cfg_register #(
  parameter int CFG_DATA_WIDTH = 1024,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic [CFG_DATA_WIDTH-1:0]   cfg_data,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready
);

  localparam int STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB  = $clog2(STRB_W);
  localparam int CFG_SIZE  = CFG_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int CFG_WIDTH = (CFG_SIZE > 1) ? $clog2(CFG_SIZE) : 1;
  localparam logic [CFG_WIDTH:0] CFG_SIZE_W = (CFG_WIDTH + 1)'(CFG_SIZE);

  logic [CFG_WIDTH-1:0]      aw_idx_q, aw_idx_d;
  logic                      aw_full_q, aw_full_d;
  logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]         w_strb_q, w_strb_d;
  logic                      w_full_q, w_full_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [CFG_DATA_WIDTH-1:0] cfg_q, cfg_d;

  logic aw_hs, w_hs, commit, idx_ok;
  logic unused_addr;

  // Only the word-index bits of the address are kept; the rest are ignored.
  assign unused_addr = ^s_axi_awaddr;

  always_comb begin
    aw_hs  = s_axi_awvalid & ~aw_full_q;
    w_hs   = s_axi_wvalid & ~w_full_q;
    commit = aw_full_q & w_full_q & ~bvalid_q;
    idx_ok = ({1'b0, aw_idx_q} < CFG_SIZE_W);

    aw_idx_d  = aw_idx_q;
    aw_full_d = aw_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (aw_hs) begin
      aw_idx_d  = s_axi_awaddr[ADDR_LSB +: CFG_WIDTH];
      aw_full_d = 1'b1;
    end
    if (w_hs) begin
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
      w_full_d = 1'b1;
    end

    // commit requires bvalid_q low, so set and clear never coincide
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = idx_ok ? 2'b00 : 2'b10;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    cfg_d = cfg_q;
    if (commit && idx_ok) begin
      for (int j = 0; j < CFG_SIZE; j++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (aw_idx_q == CFG_WIDTH'(j) && w_strb_q[b])
            cfg_d[j*AXI_DATA_WIDTH + b*8 +: 8] = w_data_q[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_idx_q  <= '0;
      aw_full_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      cfg_q     <= '0;
    end else begin
      aw_idx_q  <= aw_idx_d;
      aw_full_q <= aw_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      cfg_q     <= cfg_d;
    end
  end

  assign cfg_data      = cfg_q;
  assign s_axi_awready = ~aw_full_q;
  assign s_axi_wready  = ~w_full_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_cfg_register.sv
// Directed bench for axi_cfg_register: a 1024-bit and a 96-bit instance share
// one stimulus stream, each compared against its own shadow of expected words.
module tb_axi_cfg_register;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        bready = 1'b1;

  logic [1023:0] cfg;
  logic          awready, wready, bvalid;
  logic [1:0]    bresp;
  logic [95:0]   cfg96;
  logic          awready96, wready96, bvalid96;
  logic [1:0]    bresp96;

  logic [1023:0] m1024 = '0;
  logic [1023:0] m96 = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi_cfg_register dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  axi_cfg_register #(.CFG_DATA_WIDTH(96)) dut96 (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg96),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready96),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready96),
    .s_axi_bresp(bresp96), .s_axi_bvalid(bvalid96), .s_axi_bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;       // >0: W this many cycles before AW; <0: AW first
    int          idx;        // word index in the 1024-bit instance
    logic [31:0] exp_word;
    logic [1:0]  exp_resp96;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    bit shown;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      shown = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (!shown && act[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL %s: word %0d got %h, expected %h", name, i, act[i*32 +: 32], exp[i*32 +: 32]);
          shown = 1'b1;
        end
      end
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lead);
    int aw_c, w_c, last;
    aw_c = (lead > 0) ? lead : 0;
    w_c  = (lead < 0) ? -lead : 0;
    last = (aw_c > w_c) ? aw_c : w_c;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    for (int c = 0; c <= last; c++) begin
      awvalid = (c == aw_c);
      wvalid  = (c == w_c);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (c == w_c && c < last)  chk("wready_low_while_w_buffered", {31'b0, wready}, 32'd0);
      if (c == aw_c && c < last) chk("awready_low_while_aw_buffered", {31'b0, awready}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'hF,  0,  1, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'h1122_3344, 4'hF,  3,  0, 32'h1122_3344, 2'b00};
    vecs[2] = '{32'h0000_0000, 32'hAABB_CCDD, 4'hF, -2,  0, 32'hAABB_CCDD, 2'b00};
    vecs[3] = '{32'h0000_0000, 32'h0000_0055, 4'h1,  0,  0, 32'hAABB_CC55, 2'b00};
    vecs[4] = '{32'h0000_000C, 32'h1234_5678, 4'hF,  0,  3, 32'h1234_5678, 2'b10};
    vecs[5] = '{32'h0000_01FC, 32'hCAFE_F00D, 4'hA,  0, 31, 32'hCA00_F000, 2'b10};
    vecs[6] = '{32'h0000_1008, 32'h9988_7766, 4'h6,  0,  2, 32'h0088_7700, 2'b00};
    vecs[7] = '{32'h0000_0004, 32'h0000_0000, 4'h0,  0,  1, 32'hDEAD_BEEF, 2'b00};

    #2;
    chk_wide("reset_cfg", cfg, '0);
    chk("reset_awready", {31'b0, awready}, 32'd1);
    chk("reset_wready", {31'b0, wready}, 32'd1);
    chk("reset_bvalid", {31'b0, bvalid}, 32'd0);
    chk("reset_bresp", {30'b0, bresp}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead);
      chk($sformatf("v%0d_no_bvalid_at_handshake", i), {31'b0, bvalid}, 32'd0);
      chk_wide($sformatf("v%0d_cfg_before_commit", i), cfg, m1024);
      m1024[vecs[i].idx*32 +: 32] = vecs[i].exp_word;
      if (vecs[i].exp_resp96 == 2'b00) m96[(vecs[i].idx % 4)*32 +: 32] = vecs[i].exp_word;
      tick();
      chk($sformatf("v%0d_bvalid", i), {31'b0, bvalid}, 32'd1);
      chk($sformatf("v%0d_bresp", i), {30'b0, bresp}, 32'd0);
      chk($sformatf("v%0d_bvalid96", i), {31'b0, bvalid96}, 32'd1);
      chk($sformatf("v%0d_bresp96", i), {30'b0, bresp96}, {30'b0, vecs[i].exp_resp96});
      chk_wide($sformatf("v%0d_cfg", i), cfg, m1024);
      chk_wide($sformatf("v%0d_cfg96", i), {928'b0, cfg96}, m96);
      tick();
      chk($sformatf("v%0d_bvalid_one_cycle", i), {31'b0, bvalid}, 32'd0);
    end

    // Response back-pressure: second write buffers behind a stalled response.
    bready = 1'b0;
    send(32'h0000_0008, 32'h0102_0304, 4'hF, 0);
    tick();
    m1024[2*32 +: 32] = 32'h0102_0304;
    m96[2*32 +: 32]   = 32'h0102_0304;
    chk("bp_first_bvalid", {31'b0, bvalid}, 32'd1);
    chk_wide("bp_first_cfg", cfg, m1024);
    send(32'h0000_0010, 32'h0A0B_0C0D, 4'hF, 0);
    chk("bp_awready_low", {31'b0, awready}, 32'd0);
    chk("bp_wready_low", {31'b0, wready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d_bvalid", k), {31'b0, bvalid}, 32'd1);
      chk($sformatf("bp_hold%0d_awready", k), {31'b0, awready}, 32'd0);
      chk_wide($sformatf("bp_hold%0d_cfg", k), cfg, m1024);
    end
    bready = 1'b1;
    tick();
    chk("bp_first_resp_done", {31'b0, bvalid}, 32'd0);
    chk_wide("bp_no_commit_at_bready_edge", cfg, m1024);
    tick();
    m1024[4*32 +: 32] = 32'h0A0B_0C0D;
    m96[0 +: 32]      = 32'h0A0B_0C0D;
    chk("bp_second_bvalid", {31'b0, bvalid}, 32'd1);
    chk("bp_second_bresp", {30'b0, bresp}, 32'd0);
    chk_wide("bp_second_cfg", cfg, m1024);
    chk_wide("bp_second_cfg96", {928'b0, cfg96}, m96);
    tick();
    chk("bp_second_resp_done", {31'b0, bvalid}, 32'd0);

    // Reset between AW and W acceptance discards the buffered address.
    awaddr = 32'h0000_0014;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("rst_aw_buffered", {31'b0, awready}, 32'd0);
    aresetn = 1'b0;
    #1;
    m1024 = '0;
    m96   = '0;
    chk_wide("rst_async_cfg", cfg, '0);
    chk_wide("rst_async_cfg96", {928'b0, cfg96}, '0);
    chk("rst_async_awready", {31'b0, awready}, 32'd1);
    chk("rst_async_bvalid", {31'b0, bvalid}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    wdata = 32'h7777_7777;
    wstrb = 4'hF;
    wvalid = 1'b1;
    chk("post_rst_wready", {31'b0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    chk("post_rst_w_accepted", {31'b0, wready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("w_alone%0d_bvalid", k), {31'b0, bvalid}, 32'd0);
      chk_wide($sformatf("w_alone%0d_cfg", k), cfg, m1024);
    end
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("new_aw_no_early_bvalid", {31'b0, bvalid}, 32'd0);
    tick();
    m1024[5*32 +: 32] = 32'h7777_7777;
    m96[1*32 +: 32]   = 32'h7777_7777;
    chk("new_aw_bvalid", {31'b0, bvalid}, 32'd1);
    chk_wide("new_aw_cfg", cfg, m1024);
    chk_wide("new_aw_cfg96", {928'b0, cfg96}, m96);
    tick();
    chk("new_aw_resp_done", {31'b0, bvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
